// File: rtl/synth_audio_pkg.sv
// Shared audio-path definitions: sample width and sample-buffer state encoding.
package synth_audio_pkg;

   localparam int unsigned SAMPLE_W = 24;

   typedef enum logic {
      PRIMING = 1'b0,
      RUN     = 1'b1
   } buf_state_e;

endpackage : synth_audio_pkg

// File: rtl/sample_fifo_mem.sv
// Sample storage array: independent write port, registered read port.
module sample_fifo_mem #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_W-1:0]        rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Write on wr_en; capture the addressed word on rd_en (data valid next cycle).
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule : sample_fifo_mem

// File: rtl/tick_paced_sample_buffer.sv
// Burst-in / one-sample-per-tick-out buffer with priming and underrun handling.
// Optional build macro SAMPLE_BUF_STATS_EN adds a saturating underrun counter port.
module tick_paced_sample_buffer
   import synth_audio_pkg::*;
#(
   parameter int unsigned DATA_W        = SAMPLE_W,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned PRIME_LEVEL   = 8,
   parameter int unsigned UNDERRUN_HOLD = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick_en,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DATA_W-1:0]        out_sample,
   output logic                     out_strobe,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     underrun
`ifdef SAMPLE_BUF_STATS_EN
   ,
   output logic [15:0]              underrun_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   buf_state_e        state_q, state_d;
   logic              strobe_q, strobe_d;
   logic              underrun_q, underrun_d;
   logic              sel_mem_q, sel_mem_d;
   logic [DATA_W-1:0] hold_q, hold_d;

   logic              push;
   logic              pop;
   logic [DATA_W-1:0] mem_rd_data;
   logic [DATA_W-1:0] out_cur;
   logic [DATA_W-1:0] fill;

   assign in_ready = (level_q != LVL_W'(DEPTH)) && !rst;
   assign push     = in_valid && in_ready;

   // After a pop the output comes straight from the memory read register; otherwise from the hold register.
   assign out_cur    = sel_mem_q ? mem_rd_data : hold_q;
   assign fill       = (UNDERRUN_HOLD != 0) ? out_cur : '0;
   assign out_sample = out_cur;
   assign out_strobe = strobe_q;
   assign underrun   = underrun_q;
   assign level      = level_q;

   sample_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_en   (pop),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd_data)
   );

   // Next-state: FSM, tick servicing, pointer and occupancy update.
   always_comb begin
      state_d    = state_q;
      strobe_d   = 1'b0;
      underrun_d = 1'b0;
      sel_mem_d  = 1'b0;
      hold_d     = out_cur;
      pop        = 1'b0;

      case (state_q)
         PRIMING: begin
            if (tick_en) begin
               strobe_d = 1'b1;
               hold_d   = fill;
            end
            if (level_q >= LVL_W'(PRIME_LEVEL)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (tick_en) begin
               strobe_d = 1'b1;
               if (level_q != '0) begin
                  pop       = 1'b1;
                  sel_mem_d = 1'b1;
               end else begin
                  underrun_d = 1'b1;
                  hold_d     = fill;
                  state_d    = PRIMING;
               end
            end
         end
         default: state_d = PRIMING;
      endcase

      wr_ptr_d = push ? PTR_W'(wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop  ? PTR_W'(rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         state_q    <= PRIMING;
         strobe_q   <= 1'b0;
         underrun_q <= 1'b0;
         sel_mem_q  <= 1'b0;
         hold_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         state_q    <= state_d;
         strobe_q   <= strobe_d;
         underrun_q <= underrun_d;
         sel_mem_q  <= sel_mem_d;
         hold_q     <= hold_d;
      end
   end

`ifdef SAMPLE_BUF_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   // Saturating count of underrun pulses.
   always_comb begin
      cnt_d = cnt_q;
      if (underrun_d && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign underrun_cnt = cnt_q;
`endif

endmodule : tick_paced_sample_buffer

// File: tb/tb_tick_paced_sample_buffer.sv
// Self-checking bench: two instances (hold and zero-fill) driven in lockstep against a queue model.
module tb_tick_paced_sample_buffer;

   localparam int DEPTH = 16;
   localparam int PRIME = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_en = 1'b0;
   logic        in_valid = 1'b0;
   logic [23:0] in_data = '0;

   logic        in_ready1, out_strobe1, underrun1;
   logic [23:0] out_sample1;
   logic [4:0]  level1;
   logic        in_ready0, out_strobe0, underrun0;
   logic [23:0] out_sample0;
   logic [4:0]  level0;
`ifdef SAMPLE_BUF_STATS_EN
   logic [15:0] cnt1, cnt0;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [23:0] s1;
      logic [23:0] s0;
      logic        ur;
   } exp_t;

   exp_t        expq[$];
   logic [23:0] mq[$];
   logic        mrun = 1'b0;
   logic [23:0] mlast = '0;
   int          mcnt = 0;

   always #5 clk = ~clk;

   tick_paced_sample_buffer #(.UNDERRUN_HOLD(1)) dut (
      .clk(clk), .rst(rst), .tick_en(tick_en), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready1), .out_sample(out_sample1), .out_strobe(out_strobe1),
      .level(level1), .underrun(underrun1)
`ifdef SAMPLE_BUF_STATS_EN
      , .underrun_cnt(cnt1)
`endif
   );

   tick_paced_sample_buffer #(.UNDERRUN_HOLD(0)) dut0 (
      .clk(clk), .rst(rst), .tick_en(tick_en), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready0), .out_sample(out_sample0), .out_strobe(out_strobe0),
      .level(level0), .underrun(underrun0)
`ifdef SAMPLE_BUF_STATS_EN
      , .underrun_cnt(cnt0)
`endif
   );

   // One clock: drive inputs, advance the model, push expected output, then compare 1 ns after the edge.
   task automatic step(input logic r, input logic v, input logic [23:0] d, input logic t);
      exp_t e;
      int   sz;
      logic exp_strobe;
      logic run_n;
      logic do_pop;
      rst = r; in_valid = v; in_data = d; tick_en = t;
      exp_strobe = 1'b0;
      if (r) begin
         mq.delete(); expq.delete();
         mrun = 1'b0; mlast = '0; mcnt = 0;
      end else begin
         sz     = mq.size();
         run_n  = mrun;
         do_pop = t && mrun && (sz > 0);
         if (!mrun) begin
            if (sz >= PRIME) run_n = 1'b1;
         end else if (t && sz == 0) begin
            run_n = 1'b0;
         end
         if (t) begin
            exp_strobe = 1'b1;
            if (do_pop) begin
               e.s1 = mq[0]; e.s0 = mq[0]; e.ur = 1'b0;
            end else begin
               e.s1 = mlast; e.s0 = '0; e.ur = mrun;
            end
            expq.push_back(e);
            mlast = e.s1;
            if (e.ur && mcnt < 65535) mcnt++;
         end
         if (do_pop) void'(mq.pop_front());
         if (v && sz != DEPTH) mq.push_back(d);
         mrun = run_n;
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_strobe1 !== exp_strobe || out_strobe0 !== exp_strobe) begin
         errors++;
         $display("FAIL strobe: got %b/%b want %b at %0t", out_strobe1, out_strobe0, exp_strobe, $time);
      end
      if (exp_strobe && expq.size() > 0) begin
         e = expq.pop_front();
         checks++;
         if (out_sample1 !== e.s1 || out_sample0 !== e.s0) begin
            errors++;
            $display("FAIL sample: got %h/%h want %h/%h at %0t", out_sample1, out_sample0, e.s1, e.s0, $time);
         end
         checks++;
         if (underrun1 !== e.ur || underrun0 !== e.ur) begin
            errors++;
            $display("FAIL underrun: got %b/%b want %b at %0t", underrun1, underrun0, e.ur, $time);
         end
      end else begin
         checks++;
         if (underrun1 !== 1'b0 || underrun0 !== 1'b0) begin
            errors++;
            $display("FAIL underrun_idle: got %b/%b want 0 at %0t", underrun1, underrun0, $time);
         end
      end
      checks++;
      if (level1 !== 5'(mq.size()) || level0 !== 5'(mq.size())) begin
         errors++;
         $display("FAIL level: got %0d/%0d want %0d at %0t", level1, level0, mq.size(), $time);
      end
      checks++;
      if (in_ready1 !== ((mq.size() != DEPTH) && !r) || in_ready0 !== in_ready1) begin
         errors++;
         $display("FAIL in_ready: got %b/%b want %b at %0t", in_ready1, in_ready0,
                  (mq.size() != DEPTH) && !r, $time);
      end
`ifdef SAMPLE_BUF_STATS_EN
      checks++;
      if (cnt1 !== 16'(mcnt) || cnt0 !== 16'(mcnt)) begin
         errors++;
         $display("FAIL underrun_cnt: got %0d/%0d want %0d at %0t", cnt1, cnt0, mcnt, $time);
      end
`endif
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 24'h123, 1'b1);
      step(1'b1, 1'b0, '0, 1'b0);
      checks++;
      if (out_sample1 !== 24'd0 || level1 !== 5'd0 || in_ready1 !== 1'b0 || out_strobe1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: sample %h level %0d ready %b strobe %b", out_sample1, level1, in_ready1, out_strobe1);
      end
      step(1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (in_ready1 !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b want 1", in_ready1);
      end
   endtask

   task automatic test_prime_first_pop();
      for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 24'(i), 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (level1 !== 5'd8) begin
         errors++;
         $display("FAIL primed_level: got %0d want 8", level1);
      end
      step(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (out_strobe1 !== 1'b1 || out_sample1 !== 24'd1 || level1 !== 5'd7) begin
         errors++;
         $display("FAIL first_pop: strobe %b sample %h level %0d want 1/000001/7", out_strobe1, out_sample1, level1);
      end
   endtask

   task automatic test_priming_ticks();
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 24'(16'hA0 + i), 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         checks++;
         if (out_strobe1 !== 1'b1 || out_sample1 !== 24'd0 || underrun1 !== 1'b0) begin
            errors++;
            $display("FAIL priming_tick: strobe %b sample %h underrun %b want 1/000000/0", out_strobe1, out_sample1, underrun1);
         end
      end
      checks++;
      if (level1 !== 5'd3) begin
         errors++;
         $display("FAIL priming_level: got %0d want 3", level1);
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 24'(16'h100 + i), 1'b0);
      step(1'b0, 1'b1, 24'hDEAD, 1'b0);
      step(1'b0, 1'b1, 24'hDEAD, 1'b0);
      checks++;
      if (in_ready1 !== 1'b0 || level1 !== 5'd16) begin
         errors++;
         $display("FAIL full: ready %b level %0d want 0/16", in_ready1, level1);
      end
      step(1'b0, 1'b1, 24'hBEEF, 1'b1);
      checks++;
      if (level1 !== 5'd15 || in_ready1 !== 1'b1 || out_sample1 !== 24'h100) begin
         errors++;
         $display("FAIL full_tick: level %0d ready %b sample %h want 15/1/000100", level1, in_ready1, out_sample1);
      end
   endtask

   task automatic test_underrun();
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 24'(16'h10 + i), 1'b0);
      step(1'b0, 1'b1, 24'h00ABCD, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (out_sample1 !== 24'h00ABCD || out_sample0 !== 24'h00ABCD || underrun1 !== 1'b0) begin
         errors++;
         $display("FAIL last_sample: got %h/%h ur %b want 00abcd/00abcd/0", out_sample1, out_sample0, underrun1);
      end
      step(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (out_sample1 !== 24'h00ABCD || out_sample0 !== 24'd0 || underrun1 !== 1'b1 || underrun0 !== 1'b1) begin
         errors++;
         $display("FAIL underrun_out: got %h/%h ur %b/%b want 00abcd/000000 ur 1", out_sample1, out_sample0, underrun1, underrun0);
      end
      step(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (underrun1 !== 1'b0 || out_strobe1 !== 1'b1 || out_sample1 !== 24'h00ABCD) begin
         errors++;
         $display("FAIL back_to_priming: ur %b strobe %b sample %h want 0/1/00abcd", underrun1, out_strobe1, out_sample1);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 24'(16'h200 + i), 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 24'(16'h300 + i), 1'b1);
      checks++;
      if (level1 !== 5'd5) begin
         errors++;
         $display("FAIL push_pop_level: got %0d want 5", level1);
      end
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (out_sample1 !== 24'h327 || level1 !== 5'd0) begin
         errors++;
         $display("FAIL drain: sample %h level %0d want 000327/0", out_sample1, level1);
      end
      step(1'b0, 1'b1, 24'h777, 1'b1);
      checks++;
      if (underrun1 !== 1'b1 || level1 !== 5'd1 || out_sample1 !== 24'h327) begin
         errors++;
         $display("FAIL push_into_empty: ur %b level %0d sample %h want 1/1/000327", underrun1, level1, out_sample1);
      end
   endtask

`ifdef SAMPLE_BUF_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 24'(16'h400 + 16 * r + i), 1'b0);
         step(1'b0, 1'b0, '0, 1'b0);
         for (int i = 0; i < 9; i++) step(1'b0, 1'b0, '0, 1'b1);
      end
      checks++;
      if (cnt1 !== 16'd3) begin
         errors++;
         $display("FAIL stats_count: got %0d want 3", cnt1);
      end
   endtask
`endif

   task automatic test_mid_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 24'(16'h500 + i), 1'b0);
      step(1'b1, 1'b1, 24'h5FF, 1'b1);
      checks++;
      if (level1 !== 5'd0 || out_sample1 !== 24'd0 || out_strobe1 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: level %0d sample %h strobe %b want 0/000000/0", level1, out_sample1, out_strobe1);
      end
`ifdef SAMPLE_BUF_STATS_EN
      checks++;
      if (cnt1 !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset_cnt: got %0d want 0", cnt1);
      end
`endif
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_prime_first_pop();
      test_priming_ticks();
      test_full();
      test_underrun();
      test_back_to_back();
`ifdef SAMPLE_BUF_STATS_EN
      test_stats();
`endif
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_tick_paced_sample_buffer

// File: doc/tick_paced_sample_buffer.md
Name: tick_paced_sample_buffer

Overview:
Consumer side of the sample-rate clock-enable strobe. The synth engine pushes samples in bursts through a valid/ready interface at the fast clock. The block stores them and releases exactly one sample per one-cycle tick_en strobe toward the codec/DAC serializer. This decouples engine bursts from the fixed audio sample rate and handles priming and underrun.

Parameters:
DATA_W, 24, sample width in bits (two's complement)
DEPTH, 16, FIFO entries; power of 2, >= 4
PRIME_LEVEL, 8, occupancy required before playback starts or resumes; 1..DEPTH
UNDERRUN_HOLD, 1, 1 = repeat last output sample on underrun; 0 = output zero

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick_en  in  1  one-fast-cycle sample-rate strobe from the clock-enable generator
in_data  in  DATA_W  sample from synth engine
in_valid  in  1  in_data valid
in_ready  out  1  buffer can accept; push = in_valid && in_ready
out_sample  out  DATA_W  sample presented to codec side
out_strobe  out  1  one-cycle pulse: out_sample updated
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
underrun  out  1  one-cycle pulse: tick arrived in RUN with empty buffer

Behaviour:
- Reset (sync, rst high at posedge): wr/rd pointers = 0, level = 0, out_sample = 0, out_strobe = 0, underrun = 0, state = PRIMING, last sample = 0. in_ready = 0 while rst is high.
- in_ready = (level != DEPTH) && !rst; combinational from the registered level.
- Push: writes mem[wr_ptr]; wr_ptr increments modulo DEPTH; level +1.
- FSM states:
  - PRIMING: ticks do not pop. On each tick, out_strobe = 1 and out_sample = held value (UNDERRUN_HOLD=1) or 0 (UNDERRUN_HOLD=0); no underrun pulse.
  - PRIMING -> RUN at the posedge where the registered level >= PRIME_LEVEL. The level is evaluated before that cycle's push.
  - RUN, tick with level > 0: out_sample <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; level -1; out_strobe = 1.
  - RUN, tick with level == 0: out_sample = hold/zero per UNDERRUN_HOLD; out_strobe = 1; underrun = 1; next state PRIMING.
- Latency: out_strobe and out_sample are registered. They are valid on the cycle after tick_en. Every tick produces exactly one out_strobe.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Push into an empty buffer on the same cycle as a RUN tick: the tick sees empty and raises underrun. The pushed word is retained; there is no bypass.
- Full buffer and tick on the same cycle: in_ready = 0, so no push; the pop proceeds and level = DEPTH-1.
- Back-to-back tick_en on consecutive cycles: each tick is serviced independently. No merging and no drops.
- level never exceeds DEPTH and never goes below 0. in_valid while full is held off by in_ready; it is not an error.
- rst asserted mid-burst: all contents are discarded and the block returns to PRIMING next cycle.

Optional Feature:
SAMPLE_BUF_STATS_EN
- Defined: adds output underrun_cnt [15:0]. It increments on each underrun pulse, saturates at 16'hFFFF, and clears on rst.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package synth_audio_pkg: SAMPLE_W constant (24) and the buffer state encoding (PRIMING = 1'b0, RUN = 1'b1).
- Sub-module sample_fifo_mem holds the storage array with registered read and independent write/read enables.
- The top level holds pointers, level, FSM, output registers and the optional stats counter.

Test Plan:
- Reset, then push 8 samples 1..8 with no ticks -> level = 8, state RUN; first tick -> out_strobe next cycle, out_sample = 1, level = 7.
- Reset, push 3 samples, tick 5 times (PRIME_LEVEL=8) -> 5 strobes with out_sample = 0, no underrun, level stays 3.
- Fill to 16 -> in_ready = 0 and further in_valid is ignored; tick with in_valid high on the same cycle -> level = 15, then in_ready returns to 1.
- RUN with level 1, ticks on 2 consecutive cycles, last sample 0x00ABCD -> outputs 0x00ABCD then 0x00ABCD (hold) with underrun = 1 on the 2nd; state returns to PRIMING. Repeat with UNDERRUN_HOLD=0 -> 2nd output = 0.
- RUN, push and tick on the same cycle at level 5 -> level stays 5 and data order is preserved across pointer wrap (push 40 sequential values, all read back in order).
- With SAMPLE_BUF_STATS_EN, force 3 underruns -> underrun_cnt = 3; rst mid-stream -> underrun_cnt = 0, level = 0, out_sample = 0.
